// File: rtl/hovalaag_out_reader.sv
// Host readback of CPU OUT1/OUT2 values over EPP: captures writes into a circular
// buffer and answers EPP address writes and register reads at BASE_ADDR..BASE_ADDR+3.
module hovalaag_out_reader #(
  parameter int         DEPTH_LOG2 = 8,
  parameter logic [7:0] BASE_ADDR  = 8'h20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EppAstb,
  input  logic                  EppDstb,
  input  logic                  EppWR,
  input  logic [7:0]            epp_db_in,
  output logic [7:0]            epp_db_out,
  output logic                  epp_db_oe,
  output logic                  epp_wait,
  input  logic                  cap_valid,
  input  logic                  cap_select,
  input  logic [11:0]           cap_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ADDR_ACK, S_READ_ACK, S_RELEASE} state_t;

  // Two-flop synchronisers; idle level of every EPP control line is high.
  logic r_astb_m, r_astb_s;
  logic r_dstb_m, r_dstb_s;
  logic r_wr_m,   r_wr_s;

  state_t                r_state;
  logic [7:0]            r_addr;
  logic                  r_from_data;
  logic [1:0]            r_reg;
  logic                  r_wait;
  logic                  r_oe;
  logic [7:0]            r_db_out;

  logic [12:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  logic [7:0]  w_off;
  logic        w_in_map;
  logic        w_empty;
  logic        w_full;
  logic [12:0] w_head;
  logic [8:0]  w_cnt9;
  logic        w_strobe_high;
  logic        w_release;
  logic        w_pop;
  logic        w_ovf_clr;
  logic        w_push;
  logic [7:0]  w_rd_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_astb_m <= 1'b1;
      r_astb_s <= 1'b1;
      r_dstb_m <= 1'b1;
      r_dstb_s <= 1'b1;
      r_wr_m   <= 1'b1;
      r_wr_s   <= 1'b1;
    end else begin
      r_astb_m <= EppAstb;
      r_astb_s <= r_astb_m;
      r_dstb_m <= EppDstb;
      r_dstb_s <= r_dstb_m;
      r_wr_m   <= EppWR;
      r_wr_s   <= r_wr_m;
    end
  end

  // Unsigned wrap makes addresses below BASE_ADDR fall outside the map as well.
  assign w_off     = r_addr - BASE_ADDR;
  assign w_in_map  = (w_off < 8'd4);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_cnt9    = 9'(r_count);

  assign w_strobe_high = r_from_data ? r_dstb_s : r_astb_s;
  assign w_release     = (r_state == S_RELEASE) && w_strobe_high;
  assign w_pop         = w_release && r_from_data && (r_reg == 2'd3) && !w_empty;
  assign w_ovf_clr     = w_release && r_from_data && (r_reg == 2'd1);
  assign w_push        = cap_valid && (!w_full || w_pop);

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_off[1:0])
      2'd0: w_rd_byte = w_cnt9[7:0];
      2'd1: w_rd_byte = {r_overflow, 4'b0000, w_full, w_empty, w_cnt9[8]};
      2'd2: if (!w_empty) w_rd_byte = w_head[7:0];
      2'd3: if (!w_empty) w_rd_byte = {1'b0, 1'b1, 1'b0, w_head[12], w_head[11:8]};
      default: w_rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= 8'h00;
      r_from_data <= 1'b0;
      r_reg       <= 2'd0;
      r_wait      <= 1'b0;
      r_oe        <= 1'b0;
      r_db_out    <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_astb_s && !r_wr_s) begin
            r_addr      <= epp_db_in;
            r_from_data <= 1'b0;
            r_wait      <= 1'b1;
            r_state     <= S_ADDR_ACK;
          end else if (!r_dstb_s && r_wr_s && w_in_map) begin
            r_from_data <= 1'b1;
            r_reg       <= w_off[1:0];
            r_db_out    <= w_rd_byte;
            r_oe        <= 1'b1;
            r_wait      <= 1'b1;
            r_state     <= S_READ_ACK;
          end
        end
        S_ADDR_ACK, S_READ_ACK: r_state <= S_RELEASE;
        S_RELEASE: begin
          if (w_strobe_high) begin
            r_wait  <= 1'b0;
            r_oe    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {cap_select, cap_data};
  end

  // A dropped capture wins over a same-cycle STATUS clear so no loss goes unreported.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (cap_valid && !w_push) r_overflow <= 1'b1;
      else if (w_ovf_clr)       r_overflow <= 1'b0;
    end
  end

  assign epp_db_out = r_db_out;
  assign epp_db_oe  = r_oe;
  assign epp_wait   = r_wait;
  assign count      = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_hovalaag_out_reader.sv
// Directed self-checking bench for hovalaag_out_reader: EPP register reads,
// buffer fill/overflow/wrap, same-cycle capture+pop, unclaimed cycles and reset.
module tb_hovalaag_out_reader;

  logic        clk;
  logic        reset;
  logic        EppAstb, EppDstb, EppWR;
  logic [7:0]  epp_db_in;
  logic [7:0]  epp_db_out;
  logic        epp_db_oe, epp_wait;
  logic        cap_valid, cap_select;
  logic [11:0] cap_data;
  logic [8:0]  count;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  hovalaag_out_reader #(.DEPTH_LOG2(8), .BASE_ADDR(8'h20)) dut (
    .clk(clk), .reset(reset),
    .EppAstb(EppAstb), .EppDstb(EppDstb), .EppWR(EppWR),
    .epp_db_in(epp_db_in), .epp_db_out(epp_db_out),
    .epp_db_oe(epp_db_oe), .epp_wait(epp_wait),
    .cap_valid(cap_valid), .cap_select(cap_select), .cap_data(cap_data),
    .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cap_one(input logic sel, input logic [11:0] data);
    @(negedge clk);
    cap_valid = 1'b1; cap_select = sel; cap_data = data;
    @(negedge clk);
    cap_valid = 1'b0;
  endtask

  task automatic epp_addr(input logic [7:0] a);
    int n;
    @(negedge clk);
    EppWR = 1'b0; epp_db_in = a; EppAstb = 1'b0;
    n = 0;
    while (!epp_wait && n < 10) begin @(negedge clk); n++; end
    if (!epp_wait) begin
      tests++; fails++;
      $display("FAIL addr_ack: epp_wait=%b after %0d cycles, required 1", epp_wait, n);
    end
    EppAstb = 1'b1;
    n = 0;
    while (epp_wait && n < 10) begin @(negedge clk); n++; end
    if (epp_wait) begin
      tests++; fails++;
      $display("FAIL addr_release: epp_wait=%b after %0d cycles, required 0", epp_wait, n);
    end
    EppWR = 1'b1;
  endtask

  // Optionally injects a capture on the exact edge where the strobe release is seen.
  task automatic epp_read(output logic [7:0] d, input bit inj, input logic inj_sel,
                          input logic [11:0] inj_data);
    int n;
    d = 'x;
    @(negedge clk);
    EppWR = 1'b1; EppDstb = 1'b0;
    n = 0;
    while (!epp_wait && n < 10) begin @(negedge clk); n++; end
    if (!epp_wait) begin
      tests++; fails++;
      $display("FAIL read_ack: epp_wait=%b after %0d cycles, required 1", epp_wait, n);
    end else begin
      d = epp_db_oe ? epp_db_out : 8'hxx;
    end
    EppDstb = 1'b1;
    if (inj) begin
      @(posedge clk);
      @(posedge clk); #1;
      cap_valid = 1'b1; cap_select = inj_sel; cap_data = inj_data;
      @(posedge clk); #1;
      cap_valid = 1'b0;
    end
    n = 0;
    while (epp_wait && n < 10) begin @(negedge clk); n++; end
    if (epp_wait) begin
      tests++; fails++;
      $display("FAIL read_release: epp_wait=%b after %0d cycles, required 0", epp_wait, n);
    end
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    epp_addr(a);
    epp_read(d, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (epp_wait !== 1'b0) begin fails++; $display("FAIL rst_wait: got %b, required 0", epp_wait); end
    tests++; if (epp_db_oe !== 1'b0) begin fails++; $display("FAIL rst_oe: got %b, required 0", epp_db_oe); end
    tests++; if (epp_db_out !== 8'h00) begin fails++; $display("FAIL rst_dbout: got %h, required 00", epp_db_out); end
    tests++; if (count !== 9'd0) begin fails++; $display("FAIL rst_count: got %0d, required 0", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b, required 0", overflow); end
    reset = 1'b0;
    read_reg(8'h21, d);
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL rst_status: got %h, required 02", d); end
    read_reg(8'h23, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL rst_datah: got %h, required 00", d); end
    tests++; if (count !== 9'd0) begin fails++; $display("FAIL rst_empty_pop: count %0d, required 0", count); end
  endtask

  task automatic test_single();
    logic [7:0] d;
    do_reset();
    cap_one(1'b1, 12'hABC);
    tests++; if (count !== 9'd1) begin fails++; $display("FAIL single_count: got %0d, required 1", count); end
    read_reg(8'h22, d);
    tests++; if (d !== 8'hBC) begin fails++; $display("FAIL single_datal: got %h, required bc", d); end
    tests++; if (count !== 9'd1) begin fails++; $display("FAIL single_nopop: count %0d, required 1", count); end
    read_reg(8'h23, d);
    tests++; if (d !== 8'h5A) begin fails++; $display("FAIL single_datah: got %h, required 5a", d); end
    tests++; if (count !== 9'd0) begin fails++; $display("FAIL single_pop: count %0d, required 0", count); end
    read_reg(8'h21, d);
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL single_status: got %h, required 02", d); end
    tests++;
    if (epp_db_oe !== 1'b0 || epp_db_out !== 8'h02) begin
      fails++; $display("FAIL single_hold: oe=%b out=%h, required oe=0 out=02", epp_db_oe, epp_db_out);
    end
  endtask

  task automatic test_full();
    logic [7:0]  lo, hi;
    logic [11:0] got;
    int          bad;
    do_reset();
    for (int i = 0; i <= 256; i++) cap_one(1'b0, 12'(i));
    tests++; if (count !== 9'd256) begin fails++; $display("FAIL full_count: got %0d, required 256", count); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_ovf: got %b, required 1", overflow); end
    read_reg(8'h20, lo);
    tests++; if (lo !== 8'h00) begin fails++; $display("FAIL full_countl: got %h, required 00", lo); end
    read_reg(8'h21, lo);
    tests++; if (lo !== 8'h85) begin fails++; $display("FAIL full_status1: got %h, required 85", lo); end
    read_reg(8'h21, lo);
    tests++; if (lo !== 8'h05) begin fails++; $display("FAIL full_status2: got %h, required 05", lo); end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      read_reg(8'h22, lo);
      read_reg(8'h23, hi);
      got = {hi[3:0], lo};
      if (i == 0) begin
        tests++; if (got !== 12'h000) begin fails++; $display("FAIL full_first: got %h, required 000", got); end
      end
      if (i == 255) begin
        tests++; if (got !== 12'h0FF) begin fails++; $display("FAIL full_last: got %h, required 0ff", got); end
      end
      if (got !== 12'(i) || hi !== 8'h40) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL full_order: %0d wrong entries, required 0", bad); end
    read_reg(8'h23, hi);
    tests++; if (hi !== 8'h00) begin fails++; $display("FAIL full_absent: got %h, required 00", hi); end
    tests++; if (count !== 9'd0) begin fails++; $display("FAIL full_drained: count %0d, required 0", count); end
  endtask

  task automatic test_wrap();
    logic [7:0]  lo, hi;
    logic [11:0] v;
    int          bad;
    do_reset();
    for (int i = 0; i < 200; i++) cap_one(1'b0, 12'(i));
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      read_reg(8'h23, hi);
      if (hi !== 8'h40) bad++;
    end
    tests++; if (bad !== 0 || count !== 9'd0) begin fails++; $display("FAIL wrap_drain1: %0d bad, count %0d, required 0/0", bad, count); end
    for (int i = 0; i < 100; i++) cap_one(i[0], 12'(32'h800 + i * 7));
    tests++; if (count !== 9'd100) begin fails++; $display("FAIL wrap_count: got %0d, required 100", count); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      v = 12'(32'h800 + i * 7);
      read_reg(8'h22, lo);
      read_reg(8'h23, hi);
      if (lo !== v[7:0] || hi !== {3'b010, i[0], v[11:8]}) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL wrap_data: %0d wrong entries, required 0", bad); end
    tests++; if (count !== 9'd0) begin fails++; $display("FAIL wrap_drained: count %0d, required 0", count); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 256; i++) cap_one(1'b0, 12'(i));
    epp_addr(8'h23);
    epp_read(d, 1'b1, 1'b1, 12'h777);
    tests++; if (d !== 8'h40) begin fails++; $display("FAIL simul_datah: got %h, required 40", d); end
    tests++; if (count !== 9'd256) begin fails++; $display("FAIL simul_count: got %0d, required 256", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL simul_ovf: got %b, required 0", overflow); end
    read_reg(8'h21, d);
    tests++; if (d !== 8'h05) begin fails++; $display("FAIL simul_status: got %h, required 05", d); end
    read_reg(8'h22, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL simul_head: got %h, required 01", d); end
  endtask

  task automatic test_unclaimed();
    logic       seen;
    logic [7:0] d;
    do_reset();
    epp_addr(8'h05);
    @(negedge clk);
    EppWR = 1'b1; EppDstb = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen = seen | epp_wait | epp_db_oe; end
    EppDstb = 1'b1;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL unclaimed_read: wait|oe seen %b, required 0", seen); end
    repeat (4) @(negedge clk);
    epp_addr(8'h20);
    @(negedge clk);
    EppWR = 1'b0; epp_db_in = 8'h55; EppDstb = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen = seen | epp_wait | epp_db_oe; end
    EppDstb = 1'b1;
    @(negedge clk);
    EppWR = 1'b1;
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL unclaimed_write: wait|oe seen %b, required 0", seen); end
    repeat (4) @(negedge clk);
    epp_read(d, 1'b0, 1'b0, 12'h000);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL unclaimed_addr_kept: got %h, required 00", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int         n;
    do_reset();
    cap_one(1'b0, 12'h123);
    epp_addr(8'h23);
    @(negedge clk);
    EppWR = 1'b1; EppDstb = 1'b0;
    n = 0;
    while (!epp_wait && n < 10) begin @(negedge clk); n++; end
    tests++; if (epp_wait !== 1'b1) begin fails++; $display("FAIL mid_ack: wait %b, required 1", epp_wait); end
    reset = 1'b1; EppDstb = 1'b1;
    @(negedge clk);
    tests++; if (epp_wait !== 1'b0 || epp_db_oe !== 1'b0) begin fails++; $display("FAIL mid_release: wait=%b oe=%b, required 0/0", epp_wait, epp_db_oe); end
    tests++; if (count !== 9'd0) begin fails++; $display("FAIL mid_empty: count %0d, required 0", count); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    read_reg(8'h21, d);
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL mid_status: got %h, required 02", d); end
  endtask

  initial begin
    reset = 1'b1;
    EppAstb = 1'b1; EppDstb = 1'b1; EppWR = 1'b1; epp_db_in = 8'h00;
    cap_valid = 1'b0; cap_select = 1'b0; cap_data = 12'h000;
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_simultaneous();
    test_unclaimed();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
